enc_2_92_batch32: RTL and testbench

ENC_2_92_BATCH32 -- requirements
Module: enc_2_92_batch32

---
 rtl/enc_2_92_batch32.sv | 133 +++++++++++++
 tb/tb_enc_2_92_batch32.sv | 125 ++++++++++++
 2 files changed

// File: rtl/enc_2_92_batch32.sv
// Fully-connected Q4.11 layer: OUT_SIZE neurons in parallel, BATCH MACs per neuron per clock,
// one automatic run after each reset release, then saturate + ReLU into y.

module enc_2_92_batch32_mac #(
  parameter int BITSIZE = 16,
  parameter int BATCH   = 32,
  parameter int ACCW    = 48
) (
  input  logic [BATCH-1:0][BITSIZE-1:0] i_x,
  input  logic [BATCH-1:0][BITSIZE-1:0] i_w,
  output logic signed [ACCW-1:0]        o_sum
);
  logic signed [2*BITSIZE-1:0] w_p;

  always_comb begin
    o_sum = '0;
    w_p   = '0;
    for (int j = 0; j < BATCH; j++) begin
      w_p   = $signed(i_x[j]) * $signed(i_w[j]);
      o_sum = o_sum + ACCW'(w_p);
    end
  end
endmodule

module enc_2_92_batch32 #(
  parameter int BITSIZE  = 16,
  parameter int IN_SIZE  = 92,
  parameter int OUT_SIZE = 4,
  parameter int BATCH    = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [BITSIZE*IN_SIZE-1:0]       x,
  input  logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0] w,
  input  logic [BITSIZE*OUT_SIZE-1:0]      b,
  output logic [BITSIZE*OUT_SIZE-1:0]      y,
  output logic                             done_all
);
  localparam int NCHUNK = (IN_SIZE + BATCH - 1) / BATCH;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int ACCW   = 48;
  localparam int FRAC   = 11;
  localparam logic signed [ACCW-1:0] YMAX = (ACCW'(1) <<< (BITSIZE-1)) - 1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                               r_state, w_next;
  logic [KW-1:0]                        r_k;
  logic signed [ACCW-1:0]               r_acc [OUT_SIZE];
  logic [OUT_SIZE-1:0][BITSIZE-1:0]     r_y;
  logic                                 r_done;

  logic [NCHUNK-1:0][BATCH-1:0][BITSIZE-1:0]               w_xc;
  logic [OUT_SIZE-1:0][NCHUNK-1:0][BATCH-1:0][BITSIZE-1:0] w_wc;
  logic signed [ACCW-1:0]               w_sum [OUT_SIZE];
  logic [OUT_SIZE-1:0][BITSIZE-1:0]     w_res;

  // Regroup flat buses into chunk lanes; lanes beyond IN_SIZE are tied to zero.
  for (genvar c = 0; c < NCHUNK; c++) begin : g_chunk
    for (genvar j = 0; j < BATCH; j++) begin : g_lane
      if (c*BATCH + j < IN_SIZE) begin : g_in
        assign w_xc[c][j] = x[(c*BATCH+j)*BITSIZE +: BITSIZE];
        for (genvar o = 0; o < OUT_SIZE; o++) begin : g_w
          assign w_wc[o][c][j] = w[(o*IN_SIZE + c*BATCH + j)*BITSIZE +: BITSIZE];
        end
      end else begin : g_pad
        assign w_xc[c][j] = '0;
        for (genvar o = 0; o < OUT_SIZE; o++) begin : g_w
          assign w_wc[o][c][j] = '0;
        end
      end
    end
  end

  for (genvar o = 0; o < OUT_SIZE; o++) begin : g_neuron
    logic signed [ACCW-1:0] w_tot, w_shf;

    enc_2_92_batch32_mac #(.BITSIZE(BITSIZE), .BATCH(BATCH), .ACCW(ACCW)) u_mac (
      .i_x   (w_xc[r_k]),
      .i_w   (w_wc[o][r_k]),
      .o_sum (w_sum[o])
    );

    // Floor shift, then clamp; the lower clamp at 0 also implements ReLU.
    assign w_tot = r_acc[o] + (ACCW'($signed(b[o*BITSIZE +: BITSIZE])) <<< FRAC);
    assign w_shf = w_tot >>> FRAC;
    assign w_res[o] = (w_shf < 0)    ? '0 :
                      (w_shf > YMAX) ? YMAX[BITSIZE-1:0] : w_shf[BITSIZE-1:0];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = ACC;
      ACC:     if (r_k == KW'(NCHUNK-1)) w_next = DONE;
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_y     <= '0;
      r_done  <= 1'b0;
      for (int o = 0; o < OUT_SIZE; o++) r_acc[o] <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          r_k <= '0;
          for (int o = 0; o < OUT_SIZE; o++) r_acc[o] <= '0;
        end
        ACC: begin
          r_k <= r_k + 1'b1;
          for (int o = 0; o < OUT_SIZE; o++) r_acc[o] <= r_acc[o] + w_sum[o];
        end
        DONE: begin
          // Latch once; later input changes cannot reach y.
          if (!r_done) begin
            r_y    <= w_res;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign y        = r_y;
  assign done_all = r_done;
endmodule

// File: tb/tb_enc_2_92_batch32.sv
// Directed bench for enc_2_92_batch32: latency, arithmetic corner cases and reset behaviour.

module tb_enc_2_92_batch32;
  localparam int BS = 16, NI = 92, NO = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [BS*NI-1:0]      x = '0;
  logic [BS*NO*NI-1:0]   w = '0;
  logic [BS*NO-1:0]      b = '0;
  logic [BS*NO-1:0]      y;
  logic                  done_all;

  int n_chk = 0, n_err = 0;

  enc_2_92_batch32 dut (
    .clk(clk), .reset(reset), .x(x), .w(w), .b(b), .y(y), .done_all(done_all)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv);
    for (int i = 0; i < NI; i++) x[i*BS +: BS] = xv;
    for (int i = 0; i < NO*NI; i++) w[i*BS +: BS] = wv;
    for (int o = 0; o < NO; o++) b[o*BS +: BS] = bv;
  endtask

  // Two reset edges, check cleared outputs, release so the next edge is the first one low.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk({tag, "_rst_done"}, {31'd0, done_all}, 32'd0);
    chk({tag, "_rst_y"}, y[31:0] | y[63:32], 32'd0);
    reset = 1'b0;
  endtask

  task automatic run_expect(input string tag, input logic [63:0] exp);
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      if (n == 4) chk({tag, "_early"}, {31'd0, done_all}, 32'd0);
    end
    chk({tag, "_done"}, {31'd0, done_all}, 32'd1);
    for (int o = 0; o < NO; o++)
      chk($sformatf("%s_y%0d", tag, o), {16'd0, y[o*BS +: BS]}, {16'd0, exp[o*16 +: 16]});
  endtask

  initial begin
    // Baseline: 92*1.0*0.1 + 0.5 -> 19884
    set_all(16'd2048, 16'd205, 16'd1024);
    do_reset("t029");
    run_expect("t029", {4{16'd19884}});
    // Inputs changed after completion must not disturb y
    set_all(16'd0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t029_hold_done", {31'd0, done_all}, 32'd1);
    chk("t029_hold_y0", {16'd0, y[15:0]}, 32'd19884);
    chk("t029_hold_y3", {16'd0, y[63:48]}, 32'd19884);

    // Negative sum -> ReLU; reset from DONE also checked inside do_reset
    set_all(16'd2048, -16'sd205, 16'd1024);
    do_reset("t030");
    run_expect("t030", 64'd0);

    set_all(16'd32767, 16'd32767, 16'd32767);
    do_reset("t031");
    run_expect("t031", {4{16'd32767}});

    // Single element in the partial last chunk, neuron 2 only
    set_all(16'd0, 16'd0, 16'd0);
    x[91*BS +: BS] = 16'd2048;
    w[(2*NI+91)*BS +: BS] = 16'd4096;
    do_reset("t032");
    run_expect("t032", {16'd0, 16'd4096, 16'd0, 16'd0});

    // -2048 >>> 11 = -1 (floor) -> ReLU 0
    set_all(16'd0, 16'd0, 16'd0);
    x[0 +: BS] = 16'd2048;
    w[(1*NI+0)*BS +: BS] = 16'hFFFF;
    do_reset("t033a");
    run_expect("t033a", 64'd0);

    // 3 / 2048 truncates to 0
    set_all(16'd0, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      x[i*BS +: BS] = 16'd1;
      for (int o = 0; o < NO; o++) w[(o*NI+i)*BS +: BS] = 16'd1;
    end
    do_reset("t033b");
    run_expect("t033b", 64'd0);

    // 3000*3000 = 9000000 -> 4394.53 -> 4394 on neuron 0; neuron 3 via x[40] (middle chunk)
    set_all(16'd0, 16'd0, 16'd0);
    x[0 +: BS] = 16'd3000;
    w[0 +: BS] = 16'd3000;
    x[40*BS +: BS] = 16'd4096;
    w[(3*NI+40)*BS +: BS] = 16'd1000;
    b[3*BS +: BS] = 16'd5;
    do_reset("tfrac");
    run_expect("tfrac", {16'd2005, 16'd0, 16'd0, 16'd4394});

    // Reset pulse during the 2nd ACC cycle aborts, then a full run follows
    set_all(16'd2048, 16'd205, 16'd1024);
    do_reset("t034");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t034_abort_done", {31'd0, done_all}, 32'd0);
    chk("t034_abort_y", y[31:0] | y[63:32], 32'd0);
    reset = 1'b0;
    run_expect("t034", {4{16'd19884}});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
